// File: rtl/barrett_pkg.sv
// Shared constants and elaboration-time helpers for Barrett modular reducers.
// Fixed-prime wrappers derive their residue width and reciprocal from these functions.
package barrett_pkg;

  function automatic int unsigned barrett_qw(input int unsigned q);
    return $clog2(q);
  endfunction

  // floor(2^dw / q): the scaled reciprocal used for the quotient estimate
  function automatic longint unsigned barrett_mu(input int unsigned q, input int unsigned dw);
    return (longint'(1) << dw) / longint'(q);
  endfunction

  localparam int unsigned Q_DEFAULT  = 151;
  localparam int unsigned QW_DEFAULT = barrett_qw(Q_DEFAULT);
  localparam int unsigned DW_DEFAULT = 2 * QW_DEFAULT;
  localparam int unsigned MU_DEFAULT = int'(barrett_mu(Q_DEFAULT, DW_DEFAULT));

endpackage

// File: rtl/barrett_core_stage.sv
// Combinational Barrett middle step: quotient estimate from the scaled product,
// then the partial remainder x - qe*Q, which lands in 0..2Q-1.
module barrett_core_stage
  import barrett_pkg::*;
#(
  parameter int unsigned Q  = Q_DEFAULT,
  parameter int unsigned QW = barrett_qw(Q),
  parameter int unsigned DW = 2 * QW
) (
  input  logic [DW-1:0]       x,
  input  logic [2*DW-QW:0]    p1,
  output logic [QW:0]         r2
);

  localparam int unsigned PW = 2 * DW - QW + 1;

  logic [DW-QW:0] qe;
  logic [DW-1:0]  diff;
  logic           unused_bits;

  assign qe   = p1[PW-1:DW];
  // The true remainder is below 2Q, so only the low QW+1 bits of the
  // difference carry information; higher bits wrap harmlessly.
  assign diff = x - (DW'(qe) * DW'(Q));
  assign r2   = diff[QW:0];

  assign unused_bits = ^{p1[DW-1:0], diff[DW-1:QW+1]};

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Three-stage pipelined Barrett reducer: dout_r = din_a mod Q, with an opaque tag
// carried alongside and global-enable valid/ready flow control.
module barrett_reduce_pipe
  import barrett_pkg::*;
#(
  parameter int unsigned Q  = Q_DEFAULT,
  parameter int unsigned QW = barrett_qw(Q),
  parameter int unsigned DW = 2 * QW,
  parameter int unsigned TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din_a,
  input  logic [TW-1:0] tag_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] dout_r,
  output logic [TW-1:0] tag_out
);

  localparam int unsigned     MUW   = DW - QW + 1;
  localparam int unsigned     PW    = 2 * DW - QW + 1;
  localparam logic [MUW-1:0]  MU    = MUW'(barrett_mu(Q, DW));
  localparam logic [QW:0]     Q_EXT = (QW + 1)'(Q);

  // Handshake: a word moves in on in_valid && in_ready and out on
  // out_valid && out_ready. All stages advance together whenever the output
  // register is empty or being drained; in_ready never looks at in_valid.
  logic adv;

  logic          v1;
  logic [DW-1:0] x1;
  logic [PW-1:0] p1;
  logic [TW-1:0] t1;

  logic          v2;
  logic [QW:0]   r2;
  logic [TW-1:0] t2;

  logic [PW-1:0] p1_d;
  logic [QW:0]   r2_d;
  logic [QW-1:0] dout_d;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign p1_d = PW'(din_a) * PW'(MU);

  barrett_core_stage #(
    .Q  (Q),
    .QW (QW),
    .DW (DW)
  ) u_core (
    .x  (x1),
    .p1 (p1),
    .r2 (r2_d)
  );

  // The estimate undershoots by at most one multiple of Q, so one subtract suffices.
  assign dout_d = (r2 >= Q_EXT) ? QW'(r2 - Q_EXT) : r2[QW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      x1        <= '0;
      p1        <= '0;
      t1        <= '0;
      v2        <= 1'b0;
      r2        <= '0;
      t2        <= '0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      tag_out   <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      x1        <= din_a;
      p1        <= p1_d;
      t1        <= tag_in;
      v2        <= v1;
      r2        <= r2_d;
      t2        <= t1;
      out_valid <= v2;
      dout_r    <= dout_d;
      tag_out   <= t2;
    end
  end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Bench for barrett_reduce_pipe: Q=151 instance under directed, stall, toggle,
// sweep and reset traffic, plus a Q=251 instance; scoreboard queues per instance.
module tb_barrett_reduce_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Q=151 instance
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din_a;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  dout_r;
  logic [3:0]  tag_out;

  // Q=251 instance
  logic        in_valid_b;
  logic        in_ready_b;
  logic [15:0] din_a_b;
  logic [3:0]  tag_in_b;
  logic        out_valid_b;
  logic        out_ready_b;
  logic [7:0]  dout_r_b;
  logic [3:0]  tag_out_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   check_lat = 1'b0;
  int   rdy_mode  = 0;  // 0 high, 1 random, 2 toggle, 3 low
  logic rdy_bit   = 1'b1;

  logic [11:0] exp_q[$];
  int          acc_q[$];
  logic [11:0] exp2_q[$];

  barrett_reduce_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_r    (dout_r),
    .tag_out   (tag_out)
  );

  barrett_reduce_pipe #(.Q(251)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .din_a     (din_a_b),
    .tag_in    (tag_in_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .dout_r    (dout_r_b),
    .tag_out   (tag_out_b)
  );

  assign out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 3) ? 1'b0 : rdy_bit;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rdy_bit = (rdy_mode == 2) ? ~rdy_bit : 1'($urandom_range(1, 0));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops and compares on every output transfer of either instance.
  initial begin : monitor
    logic [11:0] e;
    int          a;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got tag %0d data %0d expected no output", tag_out, dout_r);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("result", {20'd0, tag_out, dout_r}, {20'd0, e});
          if (check_lat) check("latency", cyc - a, 3);
        end
      end
      if (rst_n && out_valid_b && out_ready_b) begin
        if (exp2_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out_b: got tag %0d data %0d expected no output", tag_out_b, dout_r_b);
        end else begin
          e = exp2_q.pop_front();
          check("result_b", {20'd0, tag_out_b, dout_r_b}, {20'd0, e});
        end
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [3:0] t, input logic [7:0] r);
    bit ok = 1'b0;
    in_valid = 1'b1;
    din_a    = x;
    tag_in   = t;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({t, r});
        acc_q.push_back(cyc);
        ok = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no accept for x=%0d expected accept within 100 cycles", x);
    end
  endtask

  task automatic send_b(input logic [15:0] x, input logic [3:0] t, input logic [7:0] r);
    bit ok = 1'b0;
    in_valid_b = 1'b1;
    din_a_b    = x;
    tag_in_b   = t;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready_b) begin
        exp2_q.push_back({t, r});
        ok = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_b_timeout: got no accept for x=%0d expected accept within 100 cycles", x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (exp_q.size() != 0 || exp2_q.size() != 0); n++) idle(1);
    check("drain_empty", exp_q.size(), 0);
    check("drain_empty_b", exp2_q.size(), 0);
  endtask

  initial begin : stimulus
    in_valid   = 1'b0;
    din_a      = '0;
    tag_in     = '0;
    in_valid_b = 1'b0;
    din_a_b    = '0;
    tag_in_b   = '0;
    out_ready_b = 1'b1;

    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_dout", dout_r, 0);
    check("rst_tag", tag_out, 0);
    check("rst_out_valid_b", out_valid_b, 0);
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed stream, back-to-back, fixed 3-cycle latency
    check_lat = 1'b1;
    send(16'd0,     4'd0, 8'd0);
    send(16'd150,   4'd1, 8'd150);
    send(16'd151,   4'd2, 8'd0);
    send(16'd152,   4'd3, 8'd1);
    send(16'd22800, 4'd4, 8'd150);
    send(16'd65535, 4'd5, 8'd1);
    drain();
    check_lat = 1'b0;

    // Stall with three words in flight
    rdy_mode = 3;
    send(16'd1000,  4'd6, 8'd94);
    send(16'd5000,  4'd7, 8'd17);
    send(16'd40000, 4'd8, 8'd136);
    for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_dout", dout_r, 94);
      check("stall_tag", tag_out, 6);
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    drain();

    // out_ready toggling every cycle
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      int x = i * 3001;
      send(16'(x), 4'(i), 8'(x % 151));
    end
    drain();

    // Strided sweep with random valid gaps and random out_ready
    rdy_mode = 1;
    for (int x = 0; x < 65536; x += 13) begin
      if ($urandom_range(1, 0) == 1) idle(1);
      send(16'(x), x[3:0], 8'(x % 151));
    end
    send(16'd65535, 4'hf, 8'd1);
    rdy_mode = 0;
    drain();

    // Asynchronous reset with words in flight
    rdy_mode = 3;
    send(16'd7, 4'd10, 8'd7);
    send(16'd8, 4'd11, 8'd8);
    send(16'd9, 4'd12, 8'd9);
    for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_dout", dout_r, 0);
    check("arst_tag", tag_out, 0);
    check("arst_in_ready", in_ready, 1);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_mode  = 0;
    check_lat = 1'b1;
    send(16'd300, 4'd9, 8'd149);
    drain();
    check_lat = 1'b0;

    // Q=251 instance
    send_b(16'd65535, 4'd1, 8'd24);
    for (int i = 0; i < 40; i++) begin
      int x = int'($urandom_range(65535, 0));
      send_b(16'(x), 4'(i), 8'(x % 251));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no completion expected finish before 900000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
